chan_bitstream_loader: RTL and testbench
========================================

# chan_bitstream_loader

Sequencer that configures the channel FPGAs from the bitstream stored in the on-board SPI flash. It sits directly upstream of the SPI flash interface. It claims the flash interface, loads the 4-byte flash read command into the write buffer, and drives the channel FPGA PROG_B/INIT_B/DONE handshake. It then triggers the bitstream readout and reports completion or failure to the control registers.

## Interface
- PROG_PULSE_CYCLES, 100: cycles PROG_B is held low (2 us at 50 MHz); must be ≥1.
- INIT_TIMEOUT, 24'd500000: max cycles waiting for INIT_B high after PROG_B release.
- DONE_TIMEOUT, 24'd500000: max cycles waiting for DONE high after bitstream end.
- READ_OPCODE, 8'h03: flash read opcode.
- FLASH_ADDR, 24'h000000: flash start address of the channel bitstream.
- clk  in  1  50 MHz flash-domain clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request to (re)configure channels; ignored unless idle.
- busy  out  1  high from accepted start until return to IDLE.
- cfg_done  out  1  sticky success flag; cleared on accepted start or reset.
- cfg_error  out  2  sticky: 01 = INIT timeout, 10 = DONE timeout, 00 = none; cleared on accepted start or reset.
- prog_chan_in_progress  out  1  ownership of the flash interface write buffer.
- pc_wbuf_wr_en  out  1  write-buffer write enable (level, re-synchronised downstream).
- pc_wbuf_wr_addr  out  7  write-buffer word address.
- pc_wbuf_data_in  out  32  write-buffer word, MSB sent first.
- read_bitstream  out  1  one-cycle pulse starting the bitstream read.
- end_bitstream  in  1  one-cycle pulse from the flash interface at readout end.
- chan_prog_b  out  1  channel FPGA PROG_B (active low).
- chan_init_b  in  1  channel FPGA INIT_B, asynchronous.
- chan_done  in  1  channel FPGA DONE, asynchronous.

## Operation
- chan_init_b and chan_done pass through 2-flop synchronisers. All uses are the synchronised versions.
- Command word is {READ_OPCODE, FLASH_ADDR}, written to wbuf word address 0.
- States:
  - IDLE: start → CLAIM. Latch clears cfg_done/cfg_error.
  - CLAIM: prog_chan_in_progress high, 4 cycles. Covers downstream 125 MHz sync latency. → WRITE.
  - WRITE: pc_wbuf_wr_en high for exactly 4 cycles. Addr/data are driven from CLAIM entry and held until IDLE. → PROG_LOW.
  - PROG_LOW: chan_prog_b low for PROG_PULSE_CYCLES. → WAIT_INIT.
  - WAIT_INIT: chan_prog_b high.
    - init_b_sync high → START_READ.
    - Counter reaches INIT_TIMEOUT → FAIL with error 01.
  - START_READ: read_bitstream high for one cycle. → WAIT_END.
  - WAIT_END: stays until end_bitstream. There is no timeout, because readout length is fixed downstream. → WAIT_DONE.
  - WAIT_DONE:
    - done_sync high → PASS.
    - Counter reaches DONE_TIMEOUT → FAIL with error 10.
  - PASS: cfg_done set. → IDLE.
  - FAIL: error set. → IDLE.
- prog_chan_in_progress is high in every state except IDLE.
- Timeout counters: 24-bit, zeroed on state entry, compare with ==, no wrap.
- start while busy: ignored. No queuing.
- end_bitstream outside WAIT_END: ignored.
- done_sync already high on entry to WAIT_DONE: PASS next cycle.
- Reset mid-operation: immediate return to IDLE with every output at its reset value. chan_prog_b returns high, possibly truncating the pulse. The channel is left unconfigured. No flags are set.

## Timing
- Reset values: busy=0, cfg_done=0, cfg_error=00, prog_chan_in_progress=0, pc_wbuf_wr_en=0, pc_wbuf_wr_addr=0, pc_wbuf_data_in=0, read_bitstream=0, chan_prog_b=1.
- All outputs are registered.
- busy and prog_chan_in_progress rise 1 cycle after start is sampled.
- pc_wbuf_wr_en rises 5 cycles after start. Data is stable ≥4 cycles before and ≥1 cycle after it.
- chan_prog_b falls 9 cycles after start and stays low exactly PROG_PULSE_CYCLES cycles.
- read_bitstream pulses 1 cycle after WAIT_INIT exits. Input sync adds 2 cycles of INIT_B latency.
- PASS/FAIL last 1 cycle each.
- busy and prog_chan_in_progress fall the cycle after PASS/FAIL, in the same cycle the flags are visible.

## Test plan
- Nominal run, PROG_PULSE_CYCLES=4. INIT_B rises 10 cycles after release; end_bitstream pulses 50 cycles after read_bitstream; DONE rises 3 cycles later → exactly one 4-cycle wr_en at addr 0 with data 0x03000000, one read_bitstream pulse, cfg_done=1, cfg_error=00, busy low.
- INIT_B held low, INIT_TIMEOUT=20 → cfg_error=01 exactly 20 cycles after WAIT_INIT entry, no read_bitstream pulse, chan_prog_b=1.
- DONE held low after end_bitstream, DONE_TIMEOUT=30 → cfg_error=10, cfg_done=0.
- start pulsed repeatedly while busy, plus a spurious end_bitstream during WAIT_INIT → single sequence, no state change from either.
- Reset asserted in PROG_LOW and again in WAIT_END → next cycle chan_prog_b=1 and all outputs at reset values. A fresh start then completes normally.
- Back-to-back: second start after a FAIL → flags cleared on acceptance; second run passes with cfg_done=1, cfg_error=00.

Source files
------------

// File: rtl/chan_bitstream_loader.sv
// rtl/chan_bitstream_loader.sv - channel FPGA configuration sequencer driving the SPI flash interface
module chan_bitstream_loader #(
  parameter int unsigned PROG_PULSE_CYCLES = 100,
  parameter logic [23:0] INIT_TIMEOUT      = 24'd500000,
  parameter logic [23:0] DONE_TIMEOUT      = 24'd500000,
  parameter logic [7:0]  READ_OPCODE       = 8'h03,
  parameter logic [23:0] FLASH_ADDR        = 24'h000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        cfg_done,
  output logic [1:0]  cfg_error,
  output logic        prog_chan_in_progress,
  output logic        pc_wbuf_wr_en,
  output logic [6:0]  pc_wbuf_wr_addr,
  output logic [31:0] pc_wbuf_data_in,
  output logic        read_bitstream,
  input  logic        end_bitstream,
  output logic        chan_prog_b,
  input  logic        chan_init_b,
  input  logic        chan_done
);

  localparam logic [23:0] PROG_LEN   = 24'(PROG_PULSE_CYCLES);
  localparam logic [23:0] CLAIM_LEN  = 24'd4;
  localparam logic [23:0] WRITE_LEN  = 24'd4;
  localparam logic [31:0] CMD_WORD   = {READ_OPCODE, FLASH_ADDR};

  typedef enum logic [3:0] {
    IDLE, CLAIM, WRITE, PROG_LOW, WAIT_INIT,
    START_READ, WAIT_END, WAIT_DONE, PASS, FAIL
  } state_t;

  state_t      state, state_next;
  logic [23:0] cnt, cnt_inc;
  logic        init_meta, init_sync, done_meta, done_sync;
  logic [1:0]  fail_code;

  always_ff @(posedge clk) begin
    if (reset) begin
      init_meta <= 1'b0;
      init_sync <= 1'b0;
      done_meta <= 1'b0;
      done_sync <= 1'b0;
    end else begin
      init_meta <= chan_init_b;
      init_sync <= init_meta;
      done_meta <= chan_done;
      done_sync <= done_meta;
    end
  end

  // One shared counter serves every timed state; it restarts on each state change.
  assign cnt_inc = cnt + 24'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 24'd0;
    end else begin
      state <= state_next;
      if (state_next != state)
        cnt <= 24'd0;
      else if (cnt != 24'hFFFFFF)
        cnt <= cnt_inc;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (start) state_next = CLAIM;
      CLAIM:      if (cnt_inc == CLAIM_LEN) state_next = WRITE;
      WRITE:      if (cnt_inc == WRITE_LEN) state_next = PROG_LOW;
      PROG_LOW:   if (cnt_inc == PROG_LEN) state_next = WAIT_INIT;
      WAIT_INIT: begin
        if (init_sync)
          state_next = START_READ;
        else if (cnt_inc == INIT_TIMEOUT)
          state_next = FAIL;
      end
      START_READ: state_next = WAIT_END;
      WAIT_END:   if (end_bitstream) state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (done_sync)
          state_next = PASS;
        else if (cnt_inc == DONE_TIMEOUT)
          state_next = FAIL;
      end
      PASS:       state_next = IDLE;
      FAIL:       state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy                  <= 1'b0;
      prog_chan_in_progress <= 1'b0;
      pc_wbuf_wr_en         <= 1'b0;
      pc_wbuf_data_in       <= 32'd0;
      read_bitstream        <= 1'b0;
      chan_prog_b           <= 1'b1;
      cfg_done              <= 1'b0;
      cfg_error             <= 2'b00;
      fail_code             <= 2'b00;
    end else begin
      busy                  <= (state_next != IDLE);
      prog_chan_in_progress <= (state_next != IDLE);
      pc_wbuf_wr_en         <= (state_next == WRITE);
      pc_wbuf_data_in       <= (state_next != IDLE) ? CMD_WORD : 32'd0;
      read_bitstream        <= (state_next == START_READ);
      chan_prog_b           <= (state_next != PROG_LOW);
      if (state_next == FAIL && state != FAIL)
        fail_code <= (state == WAIT_INIT) ? 2'b01 : 2'b10;
      if (state == IDLE && start) begin
        cfg_done  <= 1'b0;
        cfg_error <= 2'b00;
      end else if (state == PASS) begin
        cfg_done <= 1'b1;
      end else if (state == FAIL) begin
        cfg_error <= fail_code;
      end
    end
  end

  assign pc_wbuf_wr_addr = 7'd0;

endmodule

// File: tb/tb_chan_bitstream_loader.sv
// tb/tb_chan_bitstream_loader.sv - directed vector bench for chan_bitstream_loader
module tb_chan_bitstream_loader;

  localparam int NEVER = 9999;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        cfg_done;
  logic [1:0]  cfg_error;
  logic        prog_chan_in_progress;
  logic        pc_wbuf_wr_en;
  logic [6:0]  pc_wbuf_wr_addr;
  logic [31:0] pc_wbuf_data_in;
  logic        read_bitstream;
  logic        end_bitstream;
  logic        chan_prog_b;
  logic        chan_init_b;
  logic        chan_done;

  int n_cmp = 0;
  int n_fail = 0;

  chan_bitstream_loader #(
    .PROG_PULSE_CYCLES(4),
    .INIT_TIMEOUT(24'd20),
    .DONE_TIMEOUT(24'd30),
    .READ_OPCODE(8'h03),
    .FLASH_ADDR(24'h000000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .busy(busy),
    .cfg_done(cfg_done),
    .cfg_error(cfg_error),
    .prog_chan_in_progress(prog_chan_in_progress),
    .pc_wbuf_wr_en(pc_wbuf_wr_en),
    .pc_wbuf_wr_addr(pc_wbuf_wr_addr),
    .pc_wbuf_data_in(pc_wbuf_data_in),
    .read_bitstream(read_bitstream),
    .end_bitstream(end_bitstream),
    .chan_prog_b(chan_prog_b),
    .chan_init_b(chan_init_b),
    .chan_done(chan_done)
  );

  always #5 clk = ~clk;

  // Delays are in cycles: init relative to PROG_B release, end relative to the
  // read pulse, done relative to the end pulse (negative = DONE already high).
  typedef struct {
    int         init_dly;
    int         end_dly;
    int         done_dly;
    bit         noise;
    int         exp_rd;
    int         exp_fin;
    logic       exp_done;
    logic [1:0] exp_err;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string name);
    chk(name, {busy, cfg_done, cfg_error, prog_chan_in_progress, pc_wbuf_wr_en,
               pc_wbuf_wr_addr, pc_wbuf_data_in, read_bitstream, chan_prog_b},
        {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b1});
  endtask

  task automatic run_cfg(input vec_t v, input string tag);
    int t, rel, rd, endc, donec, wr_n, wr_first, prog_n, prog_fall, rd_n, bad, fin;
    logic prev_prog;
    chan_init_b = 1'b0;
    chan_done = 1'b0;
    end_bitstream = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    t = 0; rel = -1; rd = -1; endc = -1; donec = -1; fin = -1;
    wr_n = 0; wr_first = -1; prog_n = 0; prog_fall = -1; rd_n = 0; bad = 0;
    prev_prog = 1'b1;
    while (fin < 0 && t < 400) begin
      @(negedge clk);
      t++;
      end_bitstream = 1'b0;
      if (t == 1) begin
        chk({tag, "_busy_rise"}, {busy, prog_chan_in_progress}, 2'b11);
        chk({tag, "_flags_clear"}, {cfg_done, cfg_error}, 3'b000);
      end
      if (pc_wbuf_wr_en) begin
        wr_n++;
        if (wr_first < 0) wr_first = t;
        if (pc_wbuf_wr_addr != 7'd0 || pc_wbuf_data_in != 32'h03000000) bad++;
      end
      if (!chan_prog_b) begin
        prog_n++;
        if (prog_fall < 0) prog_fall = t;
      end
      if (chan_prog_b && !prev_prog) rel = t;
      prev_prog = chan_prog_b;
      if (read_bitstream) begin
        rd_n++;
        rd = t;
        endc = t + v.end_dly;
        if (v.done_dly != NEVER) donec = endc + v.done_dly;
      end
      if (!busy) fin = t;
      if (rel >= 0 && t == rel + v.init_dly) chan_init_b = 1'b1;
      if (t == endc) end_bitstream = 1'b1;
      if (t == donec) chan_done = 1'b1;
      if (v.noise && t == 16) end_bitstream = 1'b1;
      start = v.noise && busy && fin < 0;
    end
    start = 1'b0;
    end_bitstream = 1'b0;
    chk({tag, "_fin_cycle"}, fin, v.exp_fin);
    chk({tag, "_wr_cycles"}, wr_n, 4);
    chk({tag, "_wr_first"}, wr_first, 5);
    chk({tag, "_wr_word"}, bad, 0);
    chk({tag, "_prog_fall"}, prog_fall, 9);
    chk({tag, "_prog_len"}, prog_n, 4);
    chk({tag, "_rd_pulses"}, rd_n, (v.exp_rd < 0) ? 0 : 1);
    chk({tag, "_rd_cycle"}, rd, v.exp_rd);
    chk({tag, "_flags"}, {cfg_done, cfg_error}, {v.exp_done, v.exp_err});
    chk({tag, "_idle_outs"}, {chan_prog_b, prog_chan_in_progress, read_bitstream}, 3'b100);
    repeat (3) @(negedge clk);
    chk({tag, "_no_requeue"}, busy, 1'b0);
  endtask

  task automatic start_and_run(input int n);
    start = 1'b1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  initial begin
    //          init  end    done   noise rd   fin  done  err
    tbl[0] = '{NEVER, 50,    3,     1'b0, -1,  34,  1'b0, 2'b01};
    tbl[1] = '{10,    50,    3,     1'b0, 26,  83,  1'b1, 2'b00};
    tbl[2] = '{10,    50,    NEVER, 1'b0, 26,  108, 1'b0, 2'b10};
    tbl[3] = '{10,    50,    3,     1'b1, 26,  83,  1'b1, 2'b00};
    tbl[4] = '{0,     5,     -3,    1'b0, 16,  24,  1'b1, 2'b00};
    tbl[5] = '{2,     1,     0,     1'b0, 18,  23,  1'b1, 2'b00};

    reset = 1'b1;
    start = 1'b0;
    end_bitstream = 1'b0;
    chan_init_b = 1'b0;
    chan_done = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset_state");
    reset = 1'b0;

    for (int i = 0; i < 6; i++)
      run_cfg(tbl[i], $sformatf("vec%0d", i));

    // Reset while PROG_B is low truncates the pulse.
    start_and_run(10);
    chk("prog_low_pre", chan_prog_b, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst_prog_low");
    reset = 1'b0;

    // Reset while waiting for the end of readout; a late end pulse is then ignored.
    chan_init_b = 1'b1;
    repeat (3) @(negedge clk);
    start_and_run(20);
    chk("wait_end_pre", {busy, read_bitstream, chan_prog_b}, 3'b101);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst_wait_end");
    reset = 1'b0;
    end_bitstream = 1'b1;
    @(negedge clk);
    end_bitstream = 1'b0;
    repeat (2) @(negedge clk);
    chk("end_after_reset", busy, 1'b0);

    run_cfg(tbl[1], "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
